gray_to_binary_serial: RTL and testbench

Bit-serial Gray-code-to-binary decoder, the receive-side counterpart of the team's binary-to-Gray encoder. Accepts one Gray word through a valid/ready handshake and resolves one binary bit per clock, MSB first, using b[i] = b[i+1] ^ g[i]. Presents the result through a valid/ready handshake. Checks that consecutive accepted Gray words differ in exactly one bit, and counts violations.

---
 rtl/gray_to_binary_serial.sv | 108 ++++++++++
 tb/tb_gray_to_binary_serial.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/gray_to_binary_serial.sv
// Bit-serial Gray-to-binary decoder with a one-bit-adjacency checker and a saturating error count.
// Latency: the result is valid WIDTH-1 edges after acceptance (on the acceptance edge itself when WIDTH=1).
// Backpressure: the result is held in DONE until out_ready; no new word is accepted until the cycle after completion.
module gray_to_binary_serial #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     gray_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     binary_out,
  output logic                 adj_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_START = IDX_W'((WIDTH > 1) ? WIDTH - 2 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  // Working word: bits above idx are already binary, bits at or below idx still hold Gray.
  logic [WIDTH-1:0] work, work_nxt;
  logic [WIDTH-1:0] prev_gray;
  logic [IDX_W-1:0] idx;
  logic             have_prev;
  logic             adj_pend;

  logic             accept;
  logic             adj_next;
  logic             finish;
  logic [WIDTH-1:0] fin_bin;
  logic             fin_adj;

  assign accept   = (state == IDLE) && in_valid;
  assign adj_next = have_prev && ($countones(gray_in ^ prev_gray) != 1);

  // Result completes on the last shift, or directly on acceptance for a 1-bit word.
  assign finish  = (accept && (WIDTH == 1)) || ((state == SHIFT) && (idx == '0));
  assign fin_bin = (state == IDLE) ? gray_in : work_nxt;
  assign fin_adj = (state == IDLE) ? adj_next : adj_pend;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (WIDTH > 1) ? SHIFT : DONE;
      SHIFT:   if (idx == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Resolve the bit at idx from the binary bit just above it and its own Gray bit.
  always_comb begin
    work_nxt = work;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (idx == IDX_W'(i)) work_nxt[i] = work[i+1] ^ work[i];
    end
  end

  // Datapath: word capture, bit-serial conversion, result and error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      work       <= '0;
      prev_gray  <= '0;
      idx        <= '0;
      have_prev  <= 1'b0;
      adj_pend   <= 1'b0;
      binary_out <= '0;
      adj_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      if (accept) begin
        work      <= gray_in;
        idx       <= IDX_START;
        adj_pend  <= adj_next;
        prev_gray <= gray_in;
        have_prev <= 1'b1;
      end else if (state == SHIFT) begin
        work <= work_nxt;
        idx  <= idx - 1'b1;
      end
      if (finish) begin
        binary_out <= fin_bin;
        adj_err    <= fin_adj;
        if (fin_adj && (err_count != {ERR_CNT_W{1'b1}})) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gray_to_binary_serial.sv
// Directed bench for gray_to_binary_serial (WIDTH=4), with a second instance at ERR_CNT_W=2 sharing stimulus.
// Checks reset state, latency, decoded values, adjacency flags, backpressure hold, mid-flight reset, saturation.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_gray_to_binary_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] gray_in = 4'b0000;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, adj_err, busy;
  logic [3:0] binary_out;
  logic [7:0] err_count;

  logic       in_ready2, out_valid2, adj_err2, busy2;
  logic [3:0] binary_out2;
  logic [1:0] err_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gray_to_binary_serial #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .gray_in(gray_in),
    .out_valid(out_valid), .out_ready(out_ready), .binary_out(binary_out),
    .adj_err(adj_err), .err_count(err_count), .busy(busy)
  );

  gray_to_binary_serial #(.WIDTH(4), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .gray_in(gray_in),
    .out_valid(out_valid2), .out_ready(out_ready), .binary_out(binary_out2),
    .adj_err(adj_err2), .err_count(err_count2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  // Present one word; returns one time unit after the acceptance edge.
  task automatic accept(input logic [3:0] g);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    gray_in  = g;
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait for out_valid, checking latency (3 edges after acceptance) and result fields.
  task automatic wait_out(input string tag, input logic [3:0] exp_bin, input logic exp_adj,
                          input logic [7:0] exp_cnt, input logic [1:0] exp_cnt2);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_bin"}, 32'(binary_out), 32'(exp_bin));
    chk({tag, "_adj"}, 32'(adj_err), 32'(exp_adj));
    chk({tag, "_cnt"}, 32'(err_count), 32'(exp_cnt));
    chk({tag, "_cnt_sat"}, 32'(err_count2), 32'(exp_cnt2));
    chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid_low", 32'(out_valid), 32'd0);
    chk("hs_in_ready_back", 32'(in_ready), 32'd1);
    chk("hs_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state.
    do_reset(2);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_binary", 32'(binary_out), 32'd0);
    chk("rst_adj", 32'(adj_err), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single word, first after reset.
    accept(4'b0110); wait_out("w0110", 4'b0100, 1'b0, 8'd0, 2'd0); handshake();
    chk("hold_bin_after_hs", 32'(binary_out), 32'h4);

    // Adjacent stream ending in a non-adjacent word.
    do_reset(1);
    accept(4'b0000); wait_out("s0000", 4'b0000, 1'b0, 8'd0, 2'd0); handshake();
    accept(4'b0001); wait_out("s0001", 4'b0001, 1'b0, 8'd0, 2'd0); handshake();
    accept(4'b0011); wait_out("s0011", 4'b0010, 1'b0, 8'd0, 2'd0); handshake();
    accept(4'b0010); wait_out("s0010", 4'b0011, 1'b0, 8'd0, 2'd0); handshake();
    accept(4'b0110); wait_out("s0110", 4'b0100, 1'b0, 8'd0, 2'd0); handshake();
    accept(4'b1000); wait_out("s1000", 4'b1111, 1'b1, 8'd1, 2'd1); handshake();

    // Non-adjacent jump, then a repeated word.
    do_reset(1);
    accept(4'b0010); wait_out("j0010", 4'b0011, 1'b0, 8'd0, 2'd0); handshake();
    accept(4'b1111); wait_out("j1111", 4'b1010, 1'b1, 8'd1, 2'd1); handshake();
    accept(4'b1111); wait_out("r1111", 4'b1010, 1'b1, 8'd2, 2'd2); handshake();

    // Backpressure with a new word waiting.
    accept(4'b1110); wait_out("b1110", 4'b1011, 1'b0, 8'd2, 2'd2);
    in_valid = 1'b1;
    gray_in  = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_bin", 32'(binary_out), 32'hB);
      chk("bp_cnt", 32'(err_count), 32'd2);
    end
    handshake();
    accept(4'b1001); wait_out("b1001", 4'b1110, 1'b1, 8'd3, 2'd3); handshake();

    // Reset while a word is in SHIFT.
    accept(4'b1100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(err_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_no_out", 32'(out_valid), 32'd0);
    end
    accept(4'b1100); wait_out("m1100", 4'b1000, 1'b0, 8'd0, 2'd0); handshake();

    // Repeated words: narrow counter saturates at 3.
    accept(4'b1100); wait_out("sat1", 4'b1000, 1'b1, 8'd1, 2'd1); handshake();
    accept(4'b1100); wait_out("sat2", 4'b1000, 1'b1, 8'd2, 2'd2); handshake();
    accept(4'b1100); wait_out("sat3", 4'b1000, 1'b1, 8'd3, 2'd3); handshake();
    accept(4'b1100); wait_out("sat4", 4'b1000, 1'b1, 8'd4, 2'd3); handshake();
    accept(4'b1100); wait_out("sat5", 4'b1000, 1'b1, 8'd5, 2'd3); handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
